// File: rtl/ysyx_23060337_ctrl_pkg.sv
// Shared encodings for the NPC control path: RV32I opcodes, the ebreak word,
// sequencer states and instruction classes (also consumed by EXU/WBU).
package ysyx_23060337_ctrl_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [31:0] EbreakInst = 32'h0010_0073;

  typedef enum logic [3:0] {
    StBoot, StFetch, StIwait, StDecode, StExec, StMreq, StMwait, StWb,
    StHalt, StIll, StErr
  } ctrl_state_e;

  typedef enum logic [3:0] {
    ClsNone, ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsBranch, ClsLoad, ClsStore,
    ClsOpImm, ClsOp, ClsSystem
  } inst_cls_e;

  function automatic inst_cls_e opcode_to_cls(input logic [6:0] op);
    inst_cls_e cls;
    cls = ClsNone;
    case (op)
      OpLui:    cls = ClsLui;
      OpAuipc:  cls = ClsAuipc;
      OpJal:    cls = ClsJal;
      OpJalr:   cls = ClsJalr;
      OpBranch: cls = ClsBranch;
      OpLoad:   cls = ClsLoad;
      OpStore:  cls = ClsStore;
      OpImm:    cls = ClsOpImm;
      OpOp:     cls = ClsOp;
      OpSystem: cls = ClsSystem;
      default:  cls = ClsNone;
    endcase
    return cls;
  endfunction

  // SYSTEM is never legal here: its only supported form (ebreak) is matched separately.
  function automatic logic cls_legal(input inst_cls_e cls, input logic [2:0] f3);
    logic ok;
    ok = 1'b1;
    case (cls)
      ClsNone, ClsSystem: ok = 1'b0;
      ClsJalr:            ok = (f3 == 3'd0);
      ClsLoad:            ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      ClsStore:           ok = (f3 <= 3'd2);
      ClsBranch:          ok = (f3 != 3'd2) && (f3 != 3'd3);
      default:            ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_23060337_ctrl_if.sv
// Handshake and enable bundle between the sequencer (master) and the
// fetch/LSU/register-file/PC side (slave).
interface ysyx_23060337_ctrl_if;
  logic       ifu_req_valid;
  logic       ifu_req_ready;
  logic       ifu_resp_valid;
  logic       inst_we;
  logic       lsu_req_valid;
  logic       lsu_req_ready;
  logic       lsu_resp_valid;
  logic       lsu_wen;
  logic [1:0] lsu_size;
  logic       rf_we;
  logic       pc_we;

  modport master (
    output ifu_req_valid, inst_we, lsu_req_valid, lsu_wen, lsu_size, rf_we, pc_we,
    input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );

  modport slave (
    input  ifu_req_valid, inst_we, lsu_req_valid, lsu_wen, lsu_size, rf_we, pc_we,
    output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid
  );
endinterface

// File: rtl/ysyx_23060337_perf_cnt.sv
// 64-bit cycle and retired-instruction counters; only compiled when
// CTRL_PERF_EN is defined.
`ifdef CTRL_PERF_EN
module ysyx_23060337_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_cycle_en,
  input  logic        i_retire,
  output logic [63:0] o_cycle,
  output logic [63:0] o_instret
);

  logic [63:0] r_cycle;
  logic [63:0] r_instret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (i_cycle_en) r_cycle <= r_cycle + 64'd1;
      if (i_retire)   r_instret <= r_instret + 64'd1;
    end
  end

  assign o_cycle   = r_cycle;
  assign o_instret = r_instret;

endmodule
`endif

// File: rtl/ysyx_23060337_ctrl.sv
// Multi-cycle NPC sequencer: fetch/decode/execute/memory/writeback with sticky
// stop states. Define CTRL_PERF_EN to add the perf_cycle/perf_instret counters.
module ysyx_23060337_ctrl
  import ysyx_23060337_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          inst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  ysyx_23060337_ctrl_if.master bus,
  output logic                 halt,
  output logic                 illegal,
  output logic                 bus_err
`ifdef CTRL_PERF_EN
  ,
  output logic [63:0]          perf_cycle,
  output logic [63:0]          perf_instret
`endif
);

  ctrl_state_e          r_state_q;
  ctrl_state_e          w_state_d;
  inst_cls_e            r_cls_q;
  inst_cls_e            w_cls;
  logic [1:0]           r_size_q;
  logic [TIMEOUT_W-1:0] r_tmo_q;
  logic [TIMEOUT_W-1:0] w_tmo_inc;
  logic                 w_tmo_hit;
  logic                 w_wait_st;
  logic                 w_legal;
  logic                 w_ebreak;
  logic                 w_mem_cls;

  assign w_cls     = opcode_to_cls(opcode);
  assign w_legal   = cls_legal(w_cls, funct3);
  assign w_ebreak  = (w_cls == ClsSystem) && (inst == EbreakInst);
  assign w_mem_cls = (r_cls_q == ClsLoad) || (r_cls_q == ClsStore);

  // A stalled cycle whose incremented count would be all-ones gives up.
  assign w_tmo_inc = r_tmo_q + 1'b1;
  assign w_tmo_hit = &w_tmo_inc;
  assign w_wait_st = (r_state_q == StFetch) || (r_state_q == StIwait) ||
                     (r_state_q == StMreq)  || (r_state_q == StMwait);

  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StBoot:   w_state_d = StFetch;
      StFetch: begin
        if (bus.ifu_req_ready)  w_state_d = StIwait;
        else if (w_tmo_hit)     w_state_d = StErr;
      end
      StIwait: begin
        if (bus.ifu_resp_valid) w_state_d = StDecode;
        else if (w_tmo_hit)     w_state_d = StErr;
      end
      StDecode: begin
        if (w_ebreak)           w_state_d = StHalt;
        else if (!w_legal)      w_state_d = StIll;
        else                    w_state_d = StExec;
      end
      StExec:   w_state_d = w_mem_cls ? StMreq : StWb;
      StMreq: begin
        if (bus.lsu_req_ready)  w_state_d = StMwait;
        else if (w_tmo_hit)     w_state_d = StErr;
      end
      StMwait: begin
        if (bus.lsu_resp_valid) w_state_d = StWb;
        else if (w_tmo_hit)     w_state_d = StErr;
      end
      StWb:     w_state_d = StFetch;
      StHalt, StIll, StErr: w_state_d = r_state_q;
      default:  w_state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= StBoot;
      r_cls_q   <= ClsNone;
      r_size_q  <= '0;
      r_tmo_q   <= '0;
    end else begin
      r_state_q <= w_state_d;
      if (r_state_q == StDecode) begin
        r_cls_q  <= w_cls;
        r_size_q <= funct3[1:0];
      end
      if (w_state_d != r_state_q) r_tmo_q <= '0;
      else if (w_wait_st)         r_tmo_q <= w_tmo_inc;
    end
  end

  // inst_we must coincide with the response beat so the word is captured before DECODE.
  always_comb begin
    bus.ifu_req_valid = (r_state_q == StFetch);
    bus.inst_we       = (r_state_q == StIwait) && bus.ifu_resp_valid;
    bus.lsu_req_valid = (r_state_q == StMreq);
    bus.lsu_wen       = (r_state_q == StMreq) && (r_cls_q == ClsStore);
    bus.lsu_size      = (r_state_q == StMreq) ? r_size_q : 2'b00;
    bus.pc_we         = (r_state_q == StWb);
    bus.rf_we         = (r_state_q == StWb) && (r_cls_q != ClsBranch) &&
                        (r_cls_q != ClsStore);
    halt              = (r_state_q == StHalt);
    illegal           = (r_state_q == StIll);
    bus_err           = (r_state_q == StErr);
  end

`ifdef CTRL_PERF_EN
  logic w_cycle_en;
  logic w_retire;

  assign w_cycle_en = (r_state_q != StBoot) && (r_state_q != StHalt) &&
                      (r_state_q != StIll)  && (r_state_q != StErr);
  assign w_retire   = (r_state_q == StWb) ||
                      ((r_state_q == StDecode) && (w_state_d == StHalt));

  ysyx_23060337_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_cycle_en (w_cycle_en),
    .i_retire   (w_retire),
    .o_cycle    (perf_cycle),
    .o_instret  (perf_instret)
  );
`endif

endmodule
